// File: rtl/seq_fetch_pkg.sv
// Shared Seq definitions: opcodes, fetch-stage state encodings and start address.
package seq_fetch_pkg;

    localparam int SEQ_INST_W = 12;
    localparam int SEQ_ADDR_W = 8;

    localparam logic [3:0] SEQ_OP_NOP = 4'h0;
    localparam logic [3:0] SEQ_OP_LDI = 4'h1;
    localparam logic [3:0] SEQ_OP_ADI = 4'h2;
    localparam logic [3:0] SEQ_OP_JMP = 4'h3;
    localparam logic [3:0] SEQ_OP_EQI = 4'h4;

    localparam logic [1:0] SEQFETCH_STATE_IDLE  = 2'd0;
    localparam logic [1:0] SEQFETCH_STATE_FETCH = 2'd1;
    localparam logic [1:0] SEQFETCH_STATE_ISSUE = 2'd2;
    localparam logic [1:0] SEQFETCH_STATE_WAIT  = 2'd3;

    localparam logic [7:0] SEQFETCH_START_ADDR = 8'h00;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] imm;
    } seq_inst_t;

    function automatic logic [SEQ_INST_W-1:0] mk_inst(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

endpackage

// File: rtl/seq_fetch_if.sv
// Host/Seq-facing bundle of the fetch stage: program load port, run control,
// Seq's next-address feedback and the issued instruction with status.
interface seq_fetch_if #(
    parameter int InstWidth = 12,
    parameter int AddrWidth = 8
);
    logic [AddrWidth-1:0] prog_addr;
    logic [InstWidth-1:0] prog_data;
    logic                 prog_wen;
    logic                 run;
    logic [AddrWidth-1:0] next;
    logic [InstWidth-1:0] inst;
    logic                 inst_en;
    logic [AddrWidth-1:0] pc;
    logic                 running;
    logic [15:0]          icount;

    modport master (
        output prog_addr, prog_data, prog_wen, run, next,
        input  inst, inst_en, pc, running, icount
    );

    modport slave (
        input  prog_addr, prog_data, prog_wen, run, next,
        output inst, inst_en, pc, running, icount
    );
endinterface

// File: rtl/seq_fetch_mem.sv
// Program store: one synchronous write port, one synchronous read port, no reset.
// Latency: read data valid one cycle after rd_en; write lands at the sampling edge.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module seq_fetch_mem #(
    parameter int InstWidth = 12,
    parameter int AddrWidth = 8
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [InstWidth-1:0] wr_dat,
    input  logic                 rd_en,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [InstWidth-1:0] rd_dat
);
    logic [InstWidth-1:0] mem [2**AddrWidth];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/seq_fetch.sv
// Instruction fetch stage feeding Seq: fetches mem[pc], issues it as a one-cycle inst_en pulse.
// Latency: run sampled at E0 -> inst_en during E1-E2; one instruction every 3 cycles.
// Backpressure: none; run low stops at the next Fetch/Wait decision, an Issue always completes.
module seq_fetch #(
    parameter int InstWidth = 12,
    parameter int AddrWidth = 8
) (
    input  logic       clock,
    input  logic       reset,
    seq_fetch_if.slave bus
);
    import seq_fetch_pkg::*;

    logic [1:0]           state;
    logic [AddrWidth-1:0] pc_q;
    logic [InstWidth-1:0] inst_q;
    logic [InstWidth-1:0] rd_dat;
    logic [15:0]          icount_q;
    logic                 mem_wr_en;
    logic                 mem_rd_en;

    // Program loads only while idle; reads only when a Fetch proceeds to Issue.
    assign mem_wr_en = (state == SEQFETCH_STATE_IDLE)  && bus.prog_wen;
    assign mem_rd_en = (state == SEQFETCH_STATE_FETCH) && bus.run;

    seq_fetch_mem #(
        .InstWidth (InstWidth),
        .AddrWidth (AddrWidth)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (bus.prog_addr),
        .wr_dat  (bus.prog_data),
        .rd_en   (mem_rd_en),
        .rd_addr (pc_q),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SEQFETCH_STATE_IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            icount_q <= '0;
        end else begin
            case (state)
                SEQFETCH_STATE_IDLE: begin
                    if (bus.run) begin
                        pc_q  <= AddrWidth'(SEQFETCH_START_ADDR);
                        state <= SEQFETCH_STATE_FETCH;
                    end
                end
                SEQFETCH_STATE_FETCH: begin
                    state <= bus.run ? SEQFETCH_STATE_ISSUE : SEQFETCH_STATE_IDLE;
                end
                SEQFETCH_STATE_ISSUE: begin
                    inst_q   <= rd_dat;
                    icount_q <= icount_q + 16'd1;
                    state    <= SEQFETCH_STATE_WAIT;
                end
                SEQFETCH_STATE_WAIT: begin
                    if (bus.run) begin
                        pc_q  <= bus.next;
                        state <= SEQFETCH_STATE_FETCH;
                    end else begin
                        state <= SEQFETCH_STATE_IDLE;
                    end
                end
                default: state <= SEQFETCH_STATE_IDLE;
            endcase
        end
    end

    // Memory has no reset, so the freshly read word is only exposed during Issue;
    // otherwise the reset-cleared hold register drives inst.
    assign bus.inst    = (state == SEQFETCH_STATE_ISSUE) ? rd_dat : inst_q;
    assign bus.inst_en = (state == SEQFETCH_STATE_ISSUE);
    assign bus.pc      = pc_q;
    assign bus.running = (state != SEQFETCH_STATE_IDLE);
    assign bus.icount  = icount_q;
endmodule

// File: tb/tb_seq_fetch.sv
// Bench for seq_fetch: program/step tables plus a scoreboard of expected issues.
module tb_seq_fetch;
    import seq_fetch_pkg::*;

    typedef struct { logic [7:0] addr; logic [11:0] data; } load_t;
    typedef struct { logic [7:0] exp_pc; logic [11:0] exp_inst; logic [7:0] nxt; } step_t;
    typedef struct { logic [11:0] inst; logic [7:0] pc; } exp_t;

    localparam logic [11:0] W_00  = {SEQ_OP_LDI, 8'hFA};
    localparam logic [11:0] W_01  = {SEQ_OP_NOP, 8'h00};
    localparam logic [11:0] W_1A  = {SEQ_OP_EQI, 8'hAA};
    localparam logic [11:0] W_05  = {SEQ_OP_ADI, 8'h5C};
    localparam logic [11:0] W_NEW = {SEQ_OP_JMP, 8'h33};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    seq_fetch_if #(.InstWidth(12), .AddrWidth(8)) bus ();

    seq_fetch #(.InstWidth(12), .AddrWidth(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    step_t       plan[$];
    load_t       loads[4];
    logic [15:0] exp_icount = '0;
    logic [11:0] last_inst = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Every inst_en pulse must match the oldest expected issue.
    always @(negedge clock) begin
        exp_t e;
        if (reset && bus.inst_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: inst=0x%0h pc=0x%0h with no issue expected", bus.inst, bus.pc);
            end else begin
                e = sb.pop_front();
                check("issue_inst", 32'(bus.inst), 32'(e.inst));
                check("issue_pc", 32'(bus.pc), 32'(e.pc));
            end
        end
    end

    task automatic load_word(input logic [7:0] a, input logic [11:0] d);
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.prog_wen  = 1'b1;
        tick();
        bus.prog_wen  = 1'b0;
    endtask

    task automatic wait_issue(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.inst_en !== 1'b1 && cyc < 12);
        if (bus.inst_en !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: no inst_en within %0d cycles, one expected", cyc);
        end
    endtask

    // Runs the steps in plan from Idle; drops run during the last Issue.
    task automatic run_seq(input int inject_at);
        int cyc;
        bus.run = 1'b1;
        for (int i = 0; i < plan.size(); i++) begin
            sb.push_back('{inst: plan[i].exp_inst, pc: plan[i].exp_pc});
            exp_icount++;
            last_inst = plan[i].exp_inst;
            wait_issue(cyc);
            check("issue_spacing", 32'(cyc), (i == 0) ? 32'd2 : 32'd3);
            check("running_in_run", 32'(bus.running), 32'd1);
            bus.next = plan[i].nxt;
            if (i == inject_at) begin
                bus.prog_addr = 8'h00;
                bus.prog_data = 12'hF02;
                bus.prog_wen  = 1'b1;
            end else begin
                bus.prog_wen  = 1'b0;
            end
        end
        bus.run      = 1'b0;
        bus.prog_wen = 1'b0;
        tick();
        tick();
        check("stop_running", 32'(bus.running), 32'd0);
        check("stop_inst_en", 32'(bus.inst_en), 32'd0);
        check("stop_icount", 32'(bus.icount), 32'(exp_icount));
        check("stop_inst_hold", 32'(bus.inst), 32'(last_inst));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_wen  = 1'b0;
        bus.run       = 1'b0;
        bus.next      = '0;

        loads[0] = '{addr: 8'h00, data: W_00};
        loads[1] = '{addr: 8'h01, data: W_01};
        loads[2] = '{addr: 8'h1A, data: W_1A};
        loads[3] = '{addr: 8'h05, data: W_05};

        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_inst", 32'(bus.inst), 32'd0);
        check("reset_inst_en", 32'(bus.inst_en), 32'd0);
        check("reset_pc", 32'(bus.pc), 32'd0);
        check("reset_running", 32'(bus.running), 32'd0);
        check("reset_icount", 32'(bus.icount), 32'd0);

        foreach (loads[i]) load_word(loads[i].addr, loads[i].data);

        // Run 1: sequential, jump to 0x1A, then 0x05; a write is attempted mid-run.
        plan.delete();
        plan.push_back('{exp_pc: 8'h00, exp_inst: W_00, nxt: 8'h01});
        plan.push_back('{exp_pc: 8'h01, exp_inst: W_01, nxt: 8'h1A});
        plan.push_back('{exp_pc: 8'h1A, exp_inst: W_1A, nxt: 8'h05});
        plan.push_back('{exp_pc: 8'h05, exp_inst: W_05, nxt: 8'h00});
        run_seq(1);

        // Run dropped during Fetch: nothing issued, back to Idle.
        bus.run = 1'b1;
        tick();
        check("fetch_running", 32'(bus.running), 32'd1);
        bus.run = 1'b0;
        tick();
        check("fetch_drop_idle", 32'(bus.running), 32'd0);
        tick();
        check("fetch_drop_inst", 32'(bus.inst), 32'(last_inst));
        check("fetch_drop_icount", 32'(bus.icount), 32'(exp_icount));

        // Run 2: restarts at 0 with mem[0] unchanged by the mid-run write.
        plan.delete();
        plan.push_back('{exp_pc: 8'h00, exp_inst: W_00, nxt: 8'h1A});
        plan.push_back('{exp_pc: 8'h1A, exp_inst: W_1A, nxt: 8'h00});
        run_seq(-1);

        // Run 3: write and run in the same Idle cycle; first fetch sees the new word.
        sb.push_back('{inst: W_NEW, pc: 8'h00});
        bus.prog_addr = 8'h00;
        bus.prog_data = W_NEW;
        bus.prog_wen  = 1'b1;
        bus.run       = 1'b1;
        wait_issue(cyc);
        bus.prog_wen  = 1'b0;
        check("wr_run_spacing", 32'(cyc), 32'd2);

        // Reset during the pulse clears outputs without waiting for a clock edge.
        #2 reset = 1'b0;
        #1;
        check("arst_inst_en", 32'(bus.inst_en), 32'd0);
        check("arst_inst", 32'(bus.inst), 32'd0);
        check("arst_running", 32'(bus.running), 32'd0);
        bus.run    = 1'b0;
        exp_icount = '0;
        last_inst  = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_icount", 32'(bus.icount), 32'd0);
        check("post_rst_pc", 32'(bus.pc), 32'd0);

        // Run 4: memory survives reset.
        plan.delete();
        plan.push_back('{exp_pc: 8'h00, exp_inst: W_NEW, nxt: 8'h1A});
        plan.push_back('{exp_pc: 8'h1A, exp_inst: W_1A, nxt: 8'h01});
        run_seq(-1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_fetch.md
# seq_fetch

Instruction fetch stage sitting directly upstream of the `Seq` sequencer. It holds a loadable 256 x 12-bit program store and drives `Seq`'s `inst`/`inst_en` inputs. It closes the loop on `Seq`'s `next` output, fetching the word at the address `Seq` requests and issuing it as a single-cycle `inst_en` pulse. The host loads the program while idle, then raises `run` to execute from address 0.

## Interface
- `InstWidth`, default 12: instruction word width (4-bit opcode + 8-bit immediate).
- `AddrWidth`, default 8: program address width; must match the width of `Seq`'s `next`.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `prog_addr` in 8: program write address.
- `prog_data` in 12: program write data.
- `prog_wen` in 1: program write strobe; honoured only in Idle.
- `run` in 1: level; high = execute, low = stop.
- `next` in 8: address of the next instruction, from `Seq`.
- `inst` out 12: instruction to `Seq`.
- `inst_en` out 1: one-cycle strobe qualifying `inst`.
- `pc` out 8: address of the word last fetched.
- `running` out 1: high in any state other than Idle.
- `icount` out 16: count of issued instructions; wraps.

## Operation
- State machine: Idle, Fetch, Issue, Wait.
- **Idle**
  - `prog_wen`=1 writes `prog_data` to `mem[prog_addr]`.
  - `run`=1 loads `pc`=0 and moves to Fetch.
- **Fetch**
  - Registers `mem[pc]` into `inst`.
  - If `run`=1, moves to Issue. If `run`=0, moves to Idle; nothing is issued and `inst` keeps its previous value.
- **Issue**
  - `inst_en`=1 for exactly this cycle.
  - Increments `icount`.
  - Always moves to Wait; a drop of `run` here does not abort the issue.
- **Wait**
  - Gives `Seq` one cycle to update `next`.
  - If `run`=1, loads `pc` from `next` and moves to Fetch. If `run`=0, moves to Idle.
- A stop followed by a new `run` restarts from address 0; execution never resumes from the old `pc`.
- `prog_wen` outside Idle is ignored and memory is unchanged.
- `prog_wen` and `run` both high in Idle in the same cycle: the write lands at that edge, and the Fetch in the following cycle sees the new data.
- `inst_en` is low in every state except Issue.
- `inst` holds its last value when not being issued.
- `icount` wraps from 0xFFFF to 0x0000.
- Reset values: state Idle, `inst`=0, `inst_en`=0, `pc`=0, `running`=0, `icount`=0.
- Program memory is not cleared by reset.
- Reset asserted mid-run: outputs clear immediately (asynchronously). An `inst_en` pulse in progress is cut short.

## Timing
- Throughput: one instruction every 3 cycles (Fetch, Issue, Wait).
- `run` sampled high in Idle at edge E0:
  - Fetch during E0–E1.
  - `inst_en`=1 with `inst`=`mem[0]` during E1–E2.
  - Wait during E2–E3; `pc` loads `next` at E3.
  - Second `inst_en` during E4–E5.
- `next` must be valid by the end of the Wait cycle, i.e. at most one cycle after `Seq` samples `inst`.
- Memory read is synchronous with 1-cycle latency. Memory write takes effect at the edge where `prog_wen` is sampled.
- `running` rises one cycle after `run` is sampled high in Idle. It falls on entry to Idle.

## Structure
- The shared `Seq` defines file holds the opcode constants. It gains `SeqFetch_State_Idle/Fetch/Issue/Wait` (2-bit) and `SeqFetch_StartAddr` (8'h00).
- Sub-module `seq_fetch_mem`: 256 x 12 array with one synchronous write port and one synchronous read port, and no reset.
- FSM, `pc`, `icount` and output registers live in `seq_fetch`.

## Test plan
- Reset with `prog_wen` and `run` low → all outputs 0 and `running`=0 after `reset` is released.
- Load `mem[0]`={LDI,8'hFA} and `mem[1]`={NOP,8'h00}; raise `run`; `next`=1 after the first issue → `inst_en` pulses carry 0xFA-LDI then NOP, 3 cycles apart; `icount`=2.
- `next`=8'h1A after the first issue, with `mem[8'h1A]`={EQI,8'hAA} → second `inst`={EQI,8'hAA}; `pc`=8'h1A.
- Drop `run` during Fetch → no `inst_en` pulse, Idle next cycle. Drop `run` during Issue → the pulse completes, then Idle. Re-raise `run` → the first fetch is from address 0.
- `prog_wen` to address 0 with 12'hF02 while running → memory unchanged; after stopping and restarting, `mem[0]` still holds the original word.
- Assert `reset` while `inst_en`=1 → `inst_en` and `inst` go to 0 immediately. After release, `icount`=0 and memory contents are preserved.
